regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file with 2 read ports, 2 write ports and a per-register busy scoreboard.
- Successor to the 2-entry, 1-write register file: generalised in width and depth.
- Adds write-priority resolution, optional write-to-read bypass, an optional hard-wired zero register, and busy tracking.
- Sits between the decode/issue stage (reads and reservations) and the writeback stage (two writes per cycle).

Parameters:
DATA_WIDTH, 8, width of each register and of the data ports
ADDR_WIDTH, 3, register address width; depth = 2**ADDR_WIDTH
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored value only
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and is never busy

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd_addr_a  input  ADDR_WIDTH  read port A address
rd_data_a  output  DATA_WIDTH  read port A data (combinational)
rd_busy_a  output  1  register at rd_addr_a has a pending producer
rd_addr_b  input  ADDR_WIDTH  read port B address
rd_data_b  output  DATA_WIDTH  read port B data (combinational)
rd_busy_b  output  1  register at rd_addr_b has a pending producer
wr0_en  input  1  write port 0 enable
wr0_addr  input  ADDR_WIDTH  write port 0 address
wr0_data  input  DATA_WIDTH  write port 0 data
wr1_en  input  1  write port 1 enable (higher priority)
wr1_addr  input  ADDR_WIDTH  write port 1 address
wr1_data  input  DATA_WIDTH  write port 1 data
rsv_en  input  1  reserve (mark busy) request
rsv_addr  input  ADDR_WIDTH  register to mark busy
busy_count  output  ADDR_WIDTH+1  number of registers currently busy (registered)

Behaviour:
- Reset: the clock is clock; the reset is reset, synchronous and active-high. On reset, all registers are cleared to 0, all busy bits are cleared and busy_count is 0. Reset overrides any write or reserve in the same cycle. Reads during reset follow the current stored state; after the reset edge they return 0 and busy 0.
- Writes take effect on the rising edge when the port enable is high.
- Write collision: if wr0 and wr1 target the same address in the same cycle, wr1 data is stored and wr0 is discarded. Both writes still count as clearing busy.
- Reads are combinational (latency 0). rd_data returns the stored value.
- With BYPASS=1: if wr1 is enabled and matches the read address, rd_data = wr1_data. Otherwise, if wr0 is enabled and matches, rd_data = wr0_data. Otherwise rd_data is the stored value.
- With BYPASS=0: a write is visible on the read ports from the cycle after the write edge.
- Busy scoreboard: one busy bit per register.
  - rsv_en sets busy[rsv_addr] on the edge.
  - Any enabled write clears busy[wr_addr] on the edge.
  - A reserve and a write to the same address in the same cycle: the reserve wins and the bit ends set. This represents a new producer issued as the old one retires.
  - Reserving an already-busy register leaves it set.
  - A write to a non-busy register is legal and leaves it clear.
- rd_busy = busy[addr], except with BYPASS=1 where rd_busy = busy[addr] & ~(matching write enabled this cycle).
- busy_count is registered and equals the population count of the busy bits after each edge. Range is 0 to 2**ADDR_WIDTH, with no wrap.
- ZERO_REG=1:
  - Reads of address 0 return 0 and busy 0, including under bypass.
  - Writes to address 0 are dropped.
  - Reserves of address 0 are ignored; busy[0] stays 0 and is excluded from busy_count.
- Out-of-range addresses cannot occur because depth is 2**ADDR_WIDTH.
- No X propagation from uninitialised storage after the first reset.

Test Plan:
- Reset, then read all 8 addresses on both ports -> rd_data 0, rd_busy 0, busy_count 0. With ZERO_REG=1, write 0xFF to address 0 -> still reads 0.
- wr0 writes 0x5A to reg 3; next cycle read A=3 -> 0x5A. With BYPASS=1, same-cycle read A=3 -> 0x5A. With BYPASS=0, same-cycle read A=3 -> 0x00.
- wr0 writes 0x11 and wr1 writes 0x22, both to reg 6, same cycle -> reg 6 reads 0x22. With BYPASS=1 the same-cycle read also shows 0x22.
- Reserve reg 2 and reg 5 on consecutive cycles -> busy_count 1 then 2, rd_busy for 2 and 5 is 1. Then write reg 2 -> busy_count 1, rd_busy for 2 is 0.
- Reserve reg 4 and wr1-write reg 4 with 0x33 in the same cycle -> reg 4 = 0x33, busy[4] = 1.
- Reserve reg 7 and write 0x44 to reg 1, then assert reset together with wr0 writing 0x99 to reg 1 -> all regs 0, busy_count 0, reg 1 reads 0 (not 0x99).

Source files
------------

// File: rtl/regfile_mp_sb_if.sv
// Bundle of read, write and reservation signals between the issue/writeback
// stages (master) and the multi-port register file (slave).
interface regfile_mp_sb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic                  rd_busy_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  rd_busy_b;
  logic                  wr0_en;
  logic [ADDR_WIDTH-1:0] wr0_addr;
  logic [DATA_WIDTH-1:0] wr0_data;
  logic                  wr1_en;
  logic [ADDR_WIDTH-1:0] wr1_addr;
  logic [DATA_WIDTH-1:0] wr1_data;
  logic                  rsv_en;
  logic [ADDR_WIDTH-1:0] rsv_addr;
  logic [ADDR_WIDTH:0]   busy_count;

  modport master (
    output rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
    input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, busy_count
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, rsv_en, rsv_addr,
    output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, busy_count
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Register file with two combinational read ports, two prioritised write
// ports and a per-register busy scoreboard with a registered population count.
module regfile_mp_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b0
) (
  input logic            clock,
  input logic            reset,
  regfile_mp_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regFile_q [DEPTH];
  logic [DATA_WIDTH-1:0] regFile_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [ADDR_WIDTH:0]   busyCount_q;
  logic [ADDR_WIDTH:0]   busyCount_d;

  logic                  wr0Ok;
  logic                  wr1Ok;
  logic                  rsvOk;
  logic [ADDR_WIDTH-1:0] rdAddr [2];
  logic [DATA_WIDTH-1:0] rdData [2];
  logic                  rdBusy [2];

  // With a hard-wired zero register, every access aimed at address 0 is dropped.
  assign wr0Ok = bus.wr0_en && !(ZERO_REG && (bus.wr0_addr == '0));
  assign wr1Ok = bus.wr1_en && !(ZERO_REG && (bus.wr1_addr == '0));
  assign rsvOk = bus.rsv_en && !(ZERO_REG && (bus.rsv_addr == '0));

  // wr1 is applied last so it wins a same-address collision; a reserve is
  // applied after both writes so a new producer outlives the retiring one.
  always_comb begin
    regFile_d   = regFile_q;
    busy_d      = busy_q;
    busyCount_d = '0;
    if (wr0Ok) begin
      regFile_d[bus.wr0_addr] = bus.wr0_data;
      busy_d[bus.wr0_addr]    = 1'b0;
    end
    if (wr1Ok) begin
      regFile_d[bus.wr1_addr] = bus.wr1_data;
      busy_d[bus.wr1_addr]    = 1'b0;
    end
    if (rsvOk) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      busyCount_d = busyCount_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regFile_q   <= '{default: '0};
      busy_q      <= '0;
      busyCount_q <= '0;
    end else begin
      regFile_q   <= regFile_d;
      busy_q      <= busy_d;
      busyCount_q <= busyCount_d;
    end
  end

  assign rdAddr[0] = bus.rd_addr_a;
  assign rdAddr[1] = bus.rd_addr_b;

  // Forwarding checks wr1 after wr0 so the higher-priority write is the one seen.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdData[p] = regFile_q[rdAddr[p]];
      rdBusy[p] = busy_q[rdAddr[p]];
      if (BYPASS) begin
        if (bus.wr0_en && (bus.wr0_addr == rdAddr[p])) begin
          rdData[p] = bus.wr0_data;
          rdBusy[p] = 1'b0;
        end
        if (bus.wr1_en && (bus.wr1_addr == rdAddr[p])) begin
          rdData[p] = bus.wr1_data;
          rdBusy[p] = 1'b0;
        end
      end
      if (ZERO_REG && (rdAddr[p] == '0)) begin
        rdData[p] = '0;
        rdBusy[p] = 1'b0;
      end
    end
  end

  assign bus.rd_data_a  = rdData[0];
  assign bus.rd_busy_a  = rdBusy[0];
  assign bus.rd_data_b  = rdData[1];
  assign bus.rd_busy_b  = rdBusy[1];
  assign bus.busy_count = busyCount_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing instance and a non-bypassing zero-register
// instance share one stimulus stream, checked against fixed vectors and a model.
module tb_regfile_mp_sb;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int NVEC  = 20;

  typedef struct packed {
    logic          rst;
    logic          w0e;
    logic [AW-1:0] w0a;
    logic [DW-1:0] w0d;
    logic          w1e;
    logic [AW-1:0] w1a;
    logic [DW-1:0] w1d;
    logic          re;
    logic [AW-1:0] ra;
    logic [AW-1:0] rdA;
    logic [AW-1:0] rdB;
  } stimT;

  // e* fields: bypass instance (both ports); z* fields: zero-register instance port A.
  typedef struct packed {
    stimT          s;
    logic [DW-1:0] eDA;
    logic          eBA;
    logic [DW-1:0] eDB;
    logic          eBB;
    logic [AW:0]   eCnt;
    logic [DW-1:0] zDA;
    logic          zBA;
    logic [AW:0]   zCnt;
  } vecT;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  stimT cur;
  vecT  vecs [NVEC];

  logic [DW-1:0] mdlMem   [2][DEPTH];
  bit            mdlBusy  [2][DEPTH];
  int            mdlCount [2];
  bit            byp      [2] = '{1'b1, 1'b0};
  bit            zr       [2] = '{1'b0, 1'b1};

  always #5 clock = ~clock;

  regfile_mp_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifA ();
  regfile_mp_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifB ();

  regfile_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1), .ZERO_REG(1'b0)) dutA (
    .clock(clock), .reset(reset), .bus(ifA.slave)
  );
  regfile_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0), .ZERO_REG(1'b1)) dutB (
    .clock(clock), .reset(reset), .bus(ifB.slave)
  );

  task automatic applyStimulus(input stimT s);
    cur   = s;
    reset = s.rst;
    ifA.wr0_en = s.w0e; ifA.wr0_addr = s.w0a; ifA.wr0_data = s.w0d;
    ifA.wr1_en = s.w1e; ifA.wr1_addr = s.w1a; ifA.wr1_data = s.w1d;
    ifA.rsv_en = s.re;  ifA.rsv_addr = s.ra;
    ifA.rd_addr_a = s.rdA; ifA.rd_addr_b = s.rdB;
    ifB.wr0_en = s.w0e; ifB.wr0_addr = s.w0a; ifB.wr0_data = s.w0d;
    ifB.wr1_en = s.w1e; ifB.wr1_addr = s.w1a; ifB.wr1_data = s.w1d;
    ifB.rsv_en = s.re;  ifB.rsv_addr = s.ra;
    ifB.rd_addr_a = s.rdA; ifB.rd_addr_b = s.rdB;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural view of a read: zero register first, then the newest write, then storage.
  function automatic void expRead(input int d, input logic [AW-1:0] a,
                                  output logic [DW-1:0] data, output logic busy);
    data = mdlMem[d][a];
    busy = mdlBusy[d][a];
    if (zr[d] && a == 0) begin
      data = '0;
      busy = 1'b0;
    end else if (byp[d] && cur.w1e && cur.w1a == a) begin
      data = cur.w1d;
      busy = 1'b0;
    end else if (byp[d] && cur.w0e && cur.w0a == a) begin
      data = cur.w0d;
      busy = 1'b0;
    end
  endfunction

  function automatic void modelUpdate();
    for (int d = 0; d < 2; d++) begin
      if (cur.rst) begin
        for (int r = 0; r < DEPTH; r++) begin
          mdlMem[d][r]  = '0;
          mdlBusy[d][r] = 1'b0;
        end
      end else begin
        if (cur.w0e && !(zr[d] && cur.w0a == 0)) begin
          mdlMem[d][cur.w0a]  = cur.w0d;
          mdlBusy[d][cur.w0a] = 1'b0;
        end
        if (cur.w1e && !(zr[d] && cur.w1a == 0)) begin
          mdlMem[d][cur.w1a]  = cur.w1d;
          mdlBusy[d][cur.w1a] = 1'b0;
        end
        if (cur.re && !(zr[d] && cur.ra == 0)) mdlBusy[d][cur.ra] = 1'b1;
      end
      mdlCount[d] = 0;
      for (int r = 0; r < DEPTH; r++) mdlCount[d] += int'(mdlBusy[d][r]);
    end
  endfunction

  task automatic modelCheck(input string tag);
    logic [DW-1:0] d;
    logic          b;
    if (!cur.rst) begin
      expRead(0, cur.rdA, d, b);
      checkOutput({tag, " bypA.dataA"}, ifA.rd_data_a, d);
      checkOutput({tag, " bypA.busyA"}, ifA.rd_busy_a, b);
      expRead(0, cur.rdB, d, b);
      checkOutput({tag, " bypA.dataB"}, ifA.rd_data_b, d);
      checkOutput({tag, " bypA.busyB"}, ifA.rd_busy_b, b);
      expRead(1, cur.rdA, d, b);
      checkOutput({tag, " zroB.dataA"}, ifB.rd_data_a, d);
      checkOutput({tag, " zroB.busyA"}, ifB.rd_busy_a, b);
      expRead(1, cur.rdB, d, b);
      checkOutput({tag, " zroB.dataB"}, ifB.rd_data_b, d);
      checkOutput({tag, " zroB.busyB"}, ifB.rd_busy_b, b);
    end
    checkOutput({tag, " bypA.count"}, ifA.busy_count, mdlCount[0]);
    checkOutput({tag, " zroB.count"}, ifB.busy_count, mdlCount[1]);
  endtask

  task automatic stepClock();
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
  endtask

  initial begin
    stimT s;
    vecs[0]  = '{'{0, 0,0,0,     0,0,0,     0,0, 0,7}, 0,    0, 0,    0, 0, 0,    0, 0};
    vecs[1]  = '{'{0, 1,0,'hFF,  0,0,0,     0,0, 0,1}, 'hFF, 0, 0,    0, 0, 0,    0, 0};
    vecs[2]  = '{'{0, 0,0,0,     0,0,0,     0,0, 0,0}, 'hFF, 0, 'hFF, 0, 0, 0,    0, 0};
    vecs[3]  = '{'{0, 1,3,'h5A,  0,0,0,     0,0, 3,3}, 'h5A, 0, 'h5A, 0, 0, 0,    0, 0};
    vecs[4]  = '{'{0, 0,0,0,     0,0,0,     0,0, 3,0}, 'h5A, 0, 'hFF, 0, 0, 'h5A, 0, 0};
    vecs[5]  = '{'{0, 1,6,'h11,  1,6,'h22,  0,0, 6,6}, 'h22, 0, 'h22, 0, 0, 0,    0, 0};
    vecs[6]  = '{'{0, 0,0,0,     0,0,0,     0,0, 6,3}, 'h22, 0, 'h5A, 0, 0, 'h22, 0, 0};
    vecs[7]  = '{'{0, 0,0,0,     0,0,0,     1,2, 2,5}, 0,    0, 0,    0, 0, 0,    0, 0};
    vecs[8]  = '{'{0, 0,0,0,     0,0,0,     1,5, 2,5}, 0,    1, 0,    0, 1, 0,    1, 1};
    vecs[9]  = '{'{0, 0,0,0,     0,0,0,     0,0, 5,2}, 0,    1, 0,    1, 2, 0,    1, 2};
    vecs[10] = '{'{0, 1,2,'h77,  0,0,0,     0,0, 2,5}, 'h77, 0, 0,    1, 2, 0,    1, 2};
    vecs[11] = '{'{0, 0,0,0,     0,0,0,     0,0, 2,5}, 'h77, 0, 0,    1, 1, 'h77, 0, 1};
    vecs[12] = '{'{0, 0,0,0,     1,4,'h33,  1,4, 4,4}, 'h33, 0, 'h33, 0, 1, 0,    0, 1};
    vecs[13] = '{'{0, 0,0,0,     0,0,0,     0,0, 4,1}, 'h33, 1, 0,    0, 2, 'h33, 1, 2};
    vecs[14] = '{'{0, 1,1,'h44,  0,0,0,     1,7, 7,1}, 0,    0, 'h44, 0, 2, 0,    0, 2};
    vecs[15] = '{'{1, 1,1,'h99,  0,0,0,     0,0, 7,4}, 0,    1, 'h33, 1, 3, 0,    1, 3};
    vecs[16] = '{'{0, 0,0,0,     0,0,0,     0,0, 1,7}, 0,    0, 0,    0, 0, 0,    0, 0};
    vecs[17] = '{'{0, 0,0,0,     0,0,0,     0,0, 4,2}, 0,    0, 0,    0, 0, 0,    0, 0};
    vecs[18] = '{'{0, 0,0,0,     0,0,0,     1,0, 0,0}, 0,    0, 0,    0, 0, 0,    0, 0};
    vecs[19] = '{'{0, 0,0,0,     0,0,0,     0,0, 0,0}, 0,    1, 0,    1, 1, 0,    0, 0};

    for (int r = 0; r < DEPTH; r++) begin
      mdlMem[0][r] = '0; mdlMem[1][r] = '0;
      mdlBusy[0][r] = 1'b0; mdlBusy[1][r] = 1'b0;
    end
    mdlCount = '{0, 0};

    s = '0;
    s.rst = 1'b1;
    applyStimulus(s);
    @(negedge clock);
    stepClock();
    stepClock();

    // After reset every address reads zero and idle on both ports.
    for (int i = 0; i < DEPTH; i++) begin
      s = '0;
      s.rdA = AW'(i);
      s.rdB = AW'(DEPTH - 1 - i);
      applyStimulus(s);
      #1;
      checkOutput($sformatf("reset a%0d dataA", i), ifA.rd_data_a, 0);
      checkOutput($sformatf("reset a%0d busyB", i), ifA.rd_busy_b, 0);
      modelCheck($sformatf("reset a%0d", i));
      stepClock();
    end

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].s);
      #1;
      checkOutput($sformatf("v%0d bypA.dataA", i), ifA.rd_data_a, vecs[i].eDA);
      checkOutput($sformatf("v%0d bypA.busyA", i), ifA.rd_busy_a, vecs[i].eBA);
      checkOutput($sformatf("v%0d bypA.dataB", i), ifA.rd_data_b, vecs[i].eDB);
      checkOutput($sformatf("v%0d bypA.busyB", i), ifA.rd_busy_b, vecs[i].eBB);
      checkOutput($sformatf("v%0d bypA.count", i), ifA.busy_count, vecs[i].eCnt);
      checkOutput($sformatf("v%0d zroB.dataA", i), ifB.rd_data_a, vecs[i].zDA);
      checkOutput($sformatf("v%0d zroB.busyA", i), ifB.rd_busy_a, vecs[i].zBA);
      checkOutput($sformatf("v%0d zroB.count", i), ifB.busy_count, vecs[i].zCnt);
      stepClock();
    end

    // Random traffic with a small address space so collisions and bypass hits are frequent.
    for (int n = 0; n < 400; n++) begin
      s.rst = ($urandom_range(0, 39) == 0);
      s.w0e = $urandom_range(0, 1) == 1;
      s.w0a = AW'($urandom_range(0, DEPTH - 1));
      s.w0d = DW'($urandom);
      s.w1e = $urandom_range(0, 2) == 0;
      s.w1a = AW'($urandom_range(0, DEPTH - 1));
      s.w1d = DW'($urandom);
      s.re  = $urandom_range(0, 1) == 1;
      s.ra  = AW'($urandom_range(0, DEPTH - 1));
      s.rdA = AW'($urandom_range(0, DEPTH - 1));
      s.rdB = AW'($urandom_range(0, DEPTH - 1));
      applyStimulus(s);
      #1;
      modelCheck($sformatf("rnd%0d", n));
      stepClock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
